// File: rtl/axi2ahb_pkg.sv
// Shared types and constants for the axi2ahb read/write burst scheduler.
package axi2ahb_pkg;

    localparam int LEN_W    = 8;
    localparam int CONSEC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } sched_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi2ahb_rw_scheduler_if.sv
// Request/grant and beat-tracking bundle between the bridge front end and the scheduler.
interface axi2ahb_rw_scheduler_if #(
    parameter int SPACEW = 9
);
    logic              wr_req_i;
    logic [7:0]        wr_len_i;
    logic              rd_req_i;
    logic [7:0]        rd_len_i;
    logic [SPACEW-1:0] rd_space_i;
    logic              beat_done_i;
    logic              ahb_err_i;
    logic              wr_gnt_o;
    logic              rd_gnt_o;
    logic              busy_o;
    logic              dir_wr_o;
    logic [7:0]        beat_cnt_o;
    logic              burst_last_o;
    logic              burst_err_o;

    // Requester side: raises bursts and reports AHB beat completion.
    modport master (
        output wr_req_i, wr_len_i, rd_req_i, rd_len_i, rd_space_i, beat_done_i, ahb_err_i,
        input  wr_gnt_o, rd_gnt_o, busy_o, dir_wr_o, beat_cnt_o, burst_last_o, burst_err_o
    );

    // Scheduler side.
    modport slave (
        input  wr_req_i, wr_len_i, rd_req_i, rd_len_i, rd_space_i, beat_done_i, ahb_err_i,
        output wr_gnt_o, rd_gnt_o, busy_o, dir_wr_o, beat_cnt_o, burst_last_o, burst_err_o
    );
endinterface

// File: rtl/axi2ahb_prio_guard.sv
// Weighted priority pick with a starvation guard for the non-priority side.
module axi2ahb_prio_guard
    import axi2ahb_pkg::*;
#(
    parameter int PRIO_WRITE = 1,
    parameter int MAX_CONSEC = 4
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic wr_elig_i,
    input  logic rd_elig_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    input  logic wr_gnt_i,
    input  logic rd_gnt_i,
    output logic pick_wr_o
);

    localparam logic [CONSEC_W-1:0] MAX_C = CONSEC_W'(MAX_CONSEC);

    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic prio_elig, other_elig, other_req, prio_gnt, other_gnt, pick_prio;

    assign prio_elig  = (PRIO_WRITE != 0) ? wr_elig_i : rd_elig_i;
    assign other_elig = (PRIO_WRITE != 0) ? rd_elig_i : wr_elig_i;
    assign other_req  = (PRIO_WRITE != 0) ? rd_req_i  : wr_req_i;
    assign prio_gnt   = (PRIO_WRITE != 0) ? wr_gnt_i  : rd_gnt_i;
    assign other_gnt  = (PRIO_WRITE != 0) ? rd_gnt_i  : wr_gnt_i;

    // Pick the priority side unless both are eligible and it has used up its run.
    always_comb begin
        pick_prio = prio_elig;
        if (prio_elig && other_elig) begin
            pick_prio = (consec_q != MAX_C);
        end
        pick_wr_o = (PRIO_WRITE != 0) ? pick_prio : !pick_prio;
    end

    // Count priority grants that overtook a waiting request; a non-priority grant resets the run.
    always_comb begin
        consec_d = consec_q;
        if (other_gnt) begin
            consec_d = '0;
        end else if (prio_gnt && other_req && (consec_q != MAX_C)) begin
            consec_d = consec_q + 1'b1;
        end
    end

    // Run-length register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            consec_q <= '0;
        end else begin
            consec_q <= consec_d;
        end
    end

endmodule

// File: rtl/axi2ahb_rw_scheduler.sv
// Burst-level owner of the single AHB master port: grants a write or read burst,
// counts its data-phase beats and releases the bus on the last or errored beat.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | bus free; arbitrate and grant in the same cycle
// ST_WR_BURST  | write burst owns the bus, counting beats
// ST_RD_BURST  | read burst owns the bus, counting beats
module axi2ahb_rw_scheduler
    import axi2ahb_pkg::*;
#(
    parameter int PRIO_WRITE = 1,
    parameter int MAX_CONSEC = 4,
    parameter int SPACEW     = 9
) (
    input logic                   HCLK,
    input logic                   HRESET,
    axi2ahb_rw_scheduler_if.slave bus
);

    // Wide enough to hold both the free-space count and len+1 (256).
    localparam int CMP_W = max_int(SPACEW, LEN_W + 1);

    sched_state_e     state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic             dir_wr_q;

    logic [CMP_W-1:0] space_ext, need_ext;
    logic wr_elig, rd_elig, pick_wr, idle, gnt_wr, gnt_rd, last_beat;

    assign space_ext = CMP_W'(bus.rd_space_i);
    assign need_ext  = CMP_W'(bus.rd_len_i) + CMP_W'(1);

    assign wr_elig = bus.wr_req_i;
    assign rd_elig = bus.rd_req_i && (space_ext >= need_ext);

    assign idle = (state_q == ST_IDLE);

    // Grants are combinational in IDLE; gated by reset so every output reads 0 while it is held.
    assign gnt_wr = idle && !HRESET && wr_elig &&  pick_wr;
    assign gnt_rd = idle && !HRESET && rd_elig && !pick_wr;

    // The terminating beat does not advance the counter, so len 255 never wraps.
    assign last_beat = bus.beat_done_i && ((beat_cnt_q == len_q) || bus.ahb_err_i);

    axi2ahb_prio_guard #(
        .PRIO_WRITE (PRIO_WRITE),
        .MAX_CONSEC (MAX_CONSEC)
    ) u_prio_guard (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .wr_elig_i (wr_elig),
        .rd_elig_i (rd_elig),
        .wr_req_i  (bus.wr_req_i),
        .rd_req_i  (bus.rd_req_i),
        .wr_gnt_i  (gnt_wr),
        .rd_gnt_i  (gnt_rd),
        .pick_wr_o (pick_wr)
    );

    // Burst FSM: latch the granted burst, count beats, return to IDLE on the last/errored beat.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            dir_wr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_wr) begin
                        len_q      <= bus.wr_len_i;
                        beat_cnt_q <= '0;
                        dir_wr_q   <= 1'b1;
                        state_q    <= ST_WR_BURST;
                    end else if (gnt_rd) begin
                        len_q      <= bus.rd_len_i;
                        beat_cnt_q <= '0;
                        dir_wr_q   <= 1'b0;
                        state_q    <= ST_RD_BURST;
                    end
                end
                ST_WR_BURST, ST_RD_BURST: begin
                    if (last_beat) begin
                        state_q <= ST_IDLE;
                    end else if (bus.beat_done_i) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_gnt_o     = gnt_wr;
    assign bus.rd_gnt_o     = gnt_rd;
    assign bus.busy_o       = !idle;
    assign bus.dir_wr_o     = dir_wr_q;
    assign bus.beat_cnt_o   = beat_cnt_q;
    assign bus.burst_last_o = !idle && last_beat;
    assign bus.burst_err_o  = !idle && bus.beat_done_i && bus.ahb_err_i;

endmodule

// File: tb/tb_axi2ahb_rw_scheduler.sv
// Scoreboard bench for the read/write burst scheduler.
module tb_axi2ahb_rw_scheduler;

    logic HCLK;
    logic HRESET;

    axi2ahb_rw_scheduler_if #(.SPACEW(9)) bus ();

    axi2ahb_rw_scheduler #(
        .PRIO_WRITE (1),
        .MAX_CONSEC (4),
        .SPACEW     (9)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit         exp_gnt[$];   // 1 = write grant expected, 0 = read
    logic [9:0] exp_end[$];   // {dir_wr, beat_cnt, err}

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every grant and burst end the DUT produces is matched in order.
    always @(negedge HCLK) begin
        bit         e;
        logic [9:0] ee;
        if (!HRESET) begin
            if (bus.wr_gnt_o || bus.rd_gnt_o) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", {bus.wr_gnt_o, bus.rd_gnt_o}, 2'b00);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_side", {bus.wr_gnt_o, bus.rd_gnt_o}, e ? 2'b10 : 2'b01);
                end
            end
            if (bus.burst_last_o) begin
                if (exp_end.size() == 0) begin
                    chk("end_unexpected", {bus.dir_wr_o, bus.beat_cnt_o, bus.burst_err_o}, 10'h3ff);
                end else begin
                    ee = exp_end.pop_front();
                    chk("burst_end", {bus.dir_wr_o, bus.beat_cnt_o, bus.burst_err_o}, ee);
                end
            end else begin
                if (bus.burst_err_o) chk("err_without_last", 1, 0);
            end
        end
    end

    // Caller is at posedge+1; raise the request, expect the grant in the same cycle, drop it.
    task automatic request(input bit wr, input logic [7:0] len);
        int n;
        exp_gnt.push_back(wr);
        if (wr) begin
            bus.wr_req_i = 1'b1;
            bus.wr_len_i = len;
        end else begin
            bus.rd_req_i = 1'b1;
            bus.rd_len_i = len;
        end
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!(wr ? bus.wr_gnt_o : bus.rd_gnt_o) && n < 20);
        chk(wr ? "wr_gnt_latency" : "rd_gnt_latency", n, 1);
        @(posedge HCLK); #1;
        if (wr) bus.wr_req_i = 1'b0;
        else    bus.rd_req_i = 1'b0;
    endtask

    // Caller is at posedge+1; one beat per cycle, err on beat index err_idx (-1 = none).
    task automatic drive_beats(input int n, input int err_idx, input bit end_chk);
        for (int i = 0; i < n; i++) begin
            bus.beat_done_i = 1'b1;
            bus.ahb_err_i   = (i == err_idx);
            @(negedge HCLK);
            chk("busy_in_burst", bus.busy_o, 1);
            chk("beat_cnt", bus.beat_cnt_o, i);
            chk("gnt_pulse_width", bus.wr_gnt_o | bus.rd_gnt_o, 0);
            @(posedge HCLK); #1;
        end
        bus.beat_done_i = 1'b0;
        bus.ahb_err_i   = 1'b0;
        if (end_chk) begin
            @(negedge HCLK);
            chk("idle_after_burst", bus.busy_o, 0);
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        int n;
        HRESET          = 1'b1;
        bus.wr_req_i    = 1'b0;
        bus.wr_len_i    = '0;
        bus.rd_req_i    = 1'b0;
        bus.rd_len_i    = '0;
        bus.rd_space_i  = '0;
        bus.beat_done_i = 1'b0;
        bus.ahb_err_i   = 1'b0;

        // Reset state
        @(posedge HCLK); #3;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_dir", bus.dir_wr_o, 0);
        chk("rst_beat_cnt", bus.beat_cnt_o, 0);
        chk("rst_gnts", {bus.wr_gnt_o, bus.rd_gnt_o}, 0);
        chk("rst_last_err", {bus.burst_last_o, bus.burst_err_o}, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Single write, len 3
        exp_end.push_back({1'b1, 8'd3, 1'b0});
        request(1'b1, 8'd3);
        drive_beats(4, -1, 1'b1);

        // Both sides held, priority write with starvation guard every 4
        bus.rd_space_i  = 9'd256;
        bus.wr_len_i    = 8'd0;
        bus.rd_len_i    = 8'd0;
        bus.wr_req_i    = 1'b1;
        bus.rd_req_i    = 1'b1;
        bus.beat_done_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_gnt.push_back((i % 5) != 4);
            exp_end.push_back({((i % 5) != 4), 8'd0, 1'b0});
        end
        n = 0;
        while (exp_gnt.size() != 0 && n < 100) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk("order_timeout", exp_gnt.size(), 0);
        bus.wr_req_i = 1'b0;
        bus.rd_req_i = 1'b0;
        n = 0;
        while (exp_end.size() != 0 && n < 20) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk("order_end_timeout", exp_end.size(), 0);
        bus.beat_done_i = 1'b0;
        @(posedge HCLK); #1;

        // Read blocked by R-queue space until space = len+1
        bus.rd_space_i = 9'd7;
        bus.rd_len_i   = 8'd7;
        bus.rd_req_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk("rd_space_block", bus.rd_gnt_o, 0);
            @(posedge HCLK); #1;
        end
        exp_gnt.push_back(1'b0);
        bus.rd_space_i = 9'd8;
        @(negedge HCLK);
        chk("rd_space_release", bus.rd_gnt_o, 1);
        @(posedge HCLK); #1;
        bus.rd_req_i = 1'b0;
        exp_end.push_back({1'b0, 8'd7, 1'b0});
        drive_beats(8, -1, 1'b1);

        // Write len 15 aborted by an error on beat 5; stray beats afterwards are not counted
        exp_end.push_back({1'b1, 8'd5, 1'b1});
        request(1'b1, 8'd15);
        drive_beats(6, 5, 1'b0);
        bus.beat_done_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("err_no_more_beats", {bus.busy_o, bus.beat_cnt_o}, {1'b0, 8'd5});
            @(posedge HCLK); #1;
        end
        bus.beat_done_i = 1'b0;

        // Reset during a read burst at beat 2
        bus.rd_space_i = 9'd256;
        request(1'b0, 8'd7);
        drive_beats(2, -1, 1'b0);
        bus.beat_done_i = 1'b1;
        bus.wr_len_i    = 8'd0;
        bus.wr_req_i    = 1'b1;
        #2;
        HRESET = 1'b1;
        #1;
        chk("midrst_busy_cnt", {bus.busy_o, bus.beat_cnt_o}, 0);
        chk("midrst_gnts", {bus.wr_gnt_o, bus.rd_gnt_o}, 0);
        chk("midrst_last", {bus.burst_last_o, bus.burst_err_o, bus.dir_wr_o}, 0);
        bus.beat_done_i = 1'b0;
        @(posedge HCLK); #1;
        exp_gnt.push_back(1'b1);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("post_rst_wr_gnt", bus.wr_gnt_o, 1);
        @(posedge HCLK); #1;
        bus.wr_req_i = 1'b0;
        exp_end.push_back({1'b1, 8'd0, 1'b0});
        drive_beats(1, -1, 1'b1);

        // len 0 read then len 255 write with a single IDLE cycle between
        exp_gnt.push_back(1'b0);
        exp_gnt.push_back(1'b1);
        exp_end.push_back({1'b0, 8'd0, 1'b0});
        exp_end.push_back({1'b1, 8'd255, 1'b0});
        bus.rd_len_i = 8'd0;
        bus.rd_req_i = 1'b1;
        @(negedge HCLK);
        chk("b2b_rd_gnt", bus.rd_gnt_o, 1);
        @(posedge HCLK); #1;
        bus.rd_req_i    = 1'b0;
        bus.wr_len_i    = 8'd255;
        bus.wr_req_i    = 1'b1;
        bus.beat_done_i = 1'b1;
        @(negedge HCLK);
        chk("b2b_rd_last_no_gnt", {bus.burst_last_o, bus.wr_gnt_o}, 2'b10);
        @(posedge HCLK); #1;
        bus.beat_done_i = 1'b0;
        @(negedge HCLK);
        chk("b2b_idle_gnt", {bus.busy_o, bus.wr_gnt_o}, 2'b01);
        @(posedge HCLK); #1;
        bus.wr_req_i = 1'b0;
        drive_beats(256, -1, 1'b1);

        repeat (3) @(posedge HCLK);
        #1;
        chk("sb_gnt_left", exp_gnt.size(), 0);
        chk("sb_end_left", exp_end.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
